// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch controller.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 8;
    localparam int FETCH_DATA_W  = 8;
    localparam int FETCH_TIMEOUT = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_ADDR,
        READ,
        DONE,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Wait counter for the READ state. It saturates at TIMEOUT-1 and flags
// terminal count, so the controller can abort a read that never completes.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic fetch_clk,
    input  logic fetch_rst_n,
    input  logic clear,
    input  logic enable,
    output logic term_cnt
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign term_cnt = (count == CNT_W'(TIMEOUT - 1));

    // Clear wins over enable; holding at terminal count keeps the counter from wrapping.
    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !term_cnt) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Single-instruction fetch controller: loads the address register, reads
// memory with a bounded wait, and reports either the instruction or a timeout.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = FETCH_TIMEOUT
) (
    input  logic              fetch_clk,
    input  logic              fetch_rst_n,
    input  logic              fetch_start,
    input  logic              fetch_jump,
    input  logic [ADDR_W-1:0] fetch_jump_addr,
    input  logic [DATA_W-1:0] fetch_mem_data,
    input  logic              fetch_mem_ready,
    output logic [ADDR_W-1:0] fetch_addr_out,
    output logic              fetch_addr_wr_en,
    output logic              fetch_mem_rd,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              fetch_instr_valid,
    output logic              fetch_err,
    output logic              fetch_busy,
    output logic [ADDR_W-1:0] fetch_pc
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] instr_q;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_term;

    // Clearing during LOAD_ADDR means the count is zero on the first READ cycle.
    assign timer_clear  = (state == LOAD_ADDR);
    assign timer_enable = (state == READ) && !fetch_mem_ready;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .fetch_clk   (fetch_clk),
        .fetch_rst_n (fetch_rst_n),
        .clear       (timer_clear),
        .enable      (timer_enable),
        .term_cnt    (timer_term)
    );

    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A jump in IDLE lands before LOAD_ADDR, so a same-cycle start fetches from the target.
    always_ff @(posedge fetch_clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else if (state == IDLE) begin
            if (fetch_jump) begin
                pc_q <= fetch_jump_addr;
            end
        end else if (state == READ && fetch_mem_ready) begin
            pc_q    <= pc_q + ADDR_W'(1);
            instr_q <= fetch_mem_data;
        end
    end

    always_comb begin
        state_next        = state;
        fetch_addr_wr_en  = 1'b0;
        fetch_mem_rd      = 1'b0;
        fetch_instr_valid = 1'b0;
        fetch_err         = 1'b0;
        fetch_busy        = 1'b1;

        unique case (state)
            IDLE: begin
                fetch_busy = 1'b0;
                if (fetch_start) begin
                    state_next = LOAD_ADDR;
                end
            end
            LOAD_ADDR: begin
                fetch_addr_wr_en = 1'b1;
                state_next       = READ;
            end
            READ: begin
                fetch_mem_rd = 1'b1;
                if (fetch_mem_ready) begin
                    state_next = DONE;
                end else if (timer_term) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                fetch_instr_valid = 1'b1;
                state_next        = IDLE;
            end
            ERR: begin
                fetch_err  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fetch_addr_out = pc_q;
    assign fetch_pc       = pc_q;
    assign fetch_instr    = instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each fetch pushes its expected outcome,
// and a negedge monitor pops and compares it when a valid or err pulse appears.
module tb_fetch_ctrl;

    logic       fetch_clk = 1'b0;
    logic       fetch_rst_n = 1'b1;
    logic       fetch_start = 1'b0;
    logic       fetch_jump = 1'b0;
    logic [7:0] fetch_jump_addr = 8'h00;
    logic [7:0] fetch_mem_data = 8'h00;
    logic       fetch_mem_ready = 1'b0;
    logic [7:0] fetch_addr_out;
    logic       fetch_addr_wr_en;
    logic       fetch_mem_rd;
    logic [7:0] fetch_instr;
    logic       fetch_instr_valid;
    logic       fetch_err;
    logic       fetch_busy;
    logic [7:0] fetch_pc;

    typedef struct {
        logic       is_err;
        logic [7:0] instr;
        logic [7:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_pc = 8'h00;
    logic [7:0] model_instr = 8'h00;

    fetch_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00),
        .TIMEOUT  (15)
    ) dut (
        .fetch_clk         (fetch_clk),
        .fetch_rst_n       (fetch_rst_n),
        .fetch_start       (fetch_start),
        .fetch_jump        (fetch_jump),
        .fetch_jump_addr   (fetch_jump_addr),
        .fetch_mem_data    (fetch_mem_data),
        .fetch_mem_ready   (fetch_mem_ready),
        .fetch_addr_out    (fetch_addr_out),
        .fetch_addr_wr_en  (fetch_addr_wr_en),
        .fetch_mem_rd      (fetch_mem_rd),
        .fetch_instr       (fetch_instr),
        .fetch_instr_valid (fetch_instr_valid),
        .fetch_err         (fetch_err),
        .fetch_busy        (fetch_busy),
        .fetch_pc          (fetch_pc)
    );

    always #5 fetch_clk = ~fetch_clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge fetch_clk);
        #1;
    endtask

    // Any completion pulse must match the oldest outstanding expectation.
    always @(negedge fetch_clk) begin
        if (fetch_instr_valid || fetch_err) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_evt", {30'd0, fetch_instr_valid, fetch_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("evt_kind", {31'd0, fetch_err}, {31'd0, e.is_err});
                check_output("evt_instr", {24'd0, fetch_instr}, {24'd0, e.instr});
                check_output("evt_pc", {24'd0, fetch_pc}, {24'd0, e.pc});
            end
        end
    end

    // ready_at: READ cycle (1-based) on which ready is raised; 0 means never.
    task automatic apply_stimulus(input bit do_jump, input logic [7:0] jaddr,
                                  input logic [7:0] data, input int ready_at,
                                  input bit noise);
        exp_t       e;
        bit         ok;
        int         rd_cycles;
        logic [7:0] fetch_addr;

        if (do_jump) model_pc = jaddr;
        fetch_addr = model_pc;
        ok = (ready_at >= 1) && (ready_at <= 15);
        if (ok) begin
            model_pc    = model_pc + 8'd1;
            model_instr = data;
        end
        e.is_err = !ok;
        e.instr  = model_instr;
        e.pc     = model_pc;
        exp_q.push_back(e);

        fetch_start     = 1'b1;
        fetch_jump      = do_jump;
        fetch_jump_addr = jaddr;
        fetch_mem_data  = data;
        fetch_mem_ready = 1'b1;
        tick();
        fetch_start     = 1'b0;
        fetch_jump      = 1'b0;
        fetch_mem_ready = 1'b0;
        check_output("load_wr_en", {31'd0, fetch_addr_wr_en}, 32'd1);
        check_output("load_mem_rd", {31'd0, fetch_mem_rd}, 32'd0);
        check_output("load_addr", {24'd0, fetch_addr_out}, {24'd0, fetch_addr});
        check_output("load_busy", {31'd0, fetch_busy}, 32'd1);
        tick();

        rd_cycles = 0;
        for (int c = 1; c <= 20 && fetch_mem_rd; c++) begin
            rd_cycles++;
            fetch_mem_ready = (c == ready_at);
            if (noise) begin
                fetch_start     = 1'b1;
                fetch_jump      = 1'b1;
                fetch_jump_addr = 8'h55;
            end
            tick();
        end
        fetch_mem_ready = 1'b0;
        fetch_start     = 1'b0;
        fetch_jump      = 1'b0;

        check_output("read_cycles", rd_cycles, ok ? ready_at : 15);
        check_output("end_pulse", {30'd0, fetch_instr_valid, fetch_err}, ok ? 32'd2 : 32'd1);
        tick();
        check_output("idle_busy", {31'd0, fetch_busy}, 32'd0);
        check_output("idle_pulse", {30'd0, fetch_instr_valid, fetch_err}, 32'd0);
        check_output("pc", {24'd0, fetch_pc}, {24'd0, model_pc});
        check_output("instr", {24'd0, fetch_instr}, {24'd0, model_instr});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        fetch_rst_n = 1'b0;
        #1;
        check_output("rst_busy", {31'd0, fetch_busy}, 32'd0);
        check_output("rst_pc", {24'd0, fetch_pc}, 32'd0);
        check_output("rst_instr", {24'd0, fetch_instr}, 32'd0);
        check_output("rst_strobes", {28'd0, fetch_addr_wr_en, fetch_mem_rd,
                                     fetch_instr_valid, fetch_err}, 32'd0);
        tick();
        tick();
        fetch_rst_n = 1'b1;
        tick();

        apply_stimulus(1'b0, 8'h00, 8'hA5, 1, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 8'h3C, 1, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h5A, 0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'hC3, 15, 1'b0);
        apply_stimulus(1'b0, 8'h00, 8'h96, 3, 1'b1);

        fetch_jump      = 1'b1;
        fetch_jump_addr = 8'h40;
        tick();
        fetch_jump = 1'b0;
        model_pc   = 8'h40;
        check_output("jump_only_busy", {31'd0, fetch_busy}, 32'd0);
        check_output("jump_only_pc", {24'd0, fetch_pc}, 32'h40);

        apply_stimulus(1'b0, 8'h00, 8'h1E, 2, 1'b0);

        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        tick();
        check_output("pre_rst_rd", {31'd0, fetch_mem_rd}, 32'd1);
        fetch_rst_n = 1'b0;
        #1;
        model_pc    = 8'h00;
        model_instr = 8'h00;
        check_output("midrst_busy", {31'd0, fetch_busy}, 32'd0);
        check_output("midrst_rd", {31'd0, fetch_mem_rd}, 32'd0);
        check_output("midrst_pc", {24'd0, fetch_pc}, 32'd0);
        check_output("midrst_instr", {24'd0, fetch_instr}, 32'd0);
        tick();
        fetch_rst_n = 1'b1;
        tick();
        check_output("post_rst_busy", {31'd0, fetch_busy}, 32'd0);

        apply_stimulus(1'b0, 8'h00, 8'h77, 1, 1'b0);

        tick();
        check_output("sb_drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: address and PC width.
REQ-002 Parameter DATA_W, default 8: instruction and memory data width.
REQ-003 Parameter RESET_PC, default 8'h00: PC value after reset.
REQ-004 Parameter TIMEOUT, default 15: maximum cycles spent in READ waiting for fetch_mem_ready.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 fetch_clk  in  1  clock; all state updates occur on its rising edge.
REQ-007 fetch_rst_n  in  1  asynchronous active-low reset.
REQ-008 fetch_start  in  1  request one instruction fetch; sampled only in IDLE.
REQ-009 fetch_jump  in  1  load PC from fetch_jump_addr; sampled only in IDLE.
REQ-010 fetch_jump_addr  in  ADDR_W  jump target.
REQ-011 fetch_mem_data  in  DATA_W  memory read data; valid when fetch_mem_ready=1.
REQ-012 fetch_mem_ready  in  1  memory data valid strobe.
REQ-013 fetch_addr_out  out  ADDR_W  current PC; drives the address register's data input.
REQ-014 fetch_addr_wr_en  out  1  write enable to the address register.
REQ-015 fetch_mem_rd  out  1  memory read strobe.
REQ-016 fetch_instr  out  DATA_W  last successfully fetched instruction.
REQ-017 fetch_instr_valid  out  1  one-cycle pulse: fetch_instr updated.
REQ-018 fetch_err  out  1  one-cycle pulse: fetch timed out.
REQ-019 fetch_busy  out  1  high in any state other than IDLE.
REQ-020 fetch_pc  out  ADDR_W  current PC, same value as fetch_addr_out.

Function
REQ-021 FSM states: IDLE, LOAD_ADDR, READ, DONE, ERR; all control outputs are Moore decodes of the state.
REQ-022 IDLE: fetch_jump=1 -> PC<=fetch_jump_addr; fetch_start=1 -> next state LOAD_ADDR; both high in the same cycle -> PC loads and the fetch uses the jump target.
REQ-023 LOAD_ADDR: fetch_addr_wr_en=1 for exactly one cycle; unconditional transition to READ.
REQ-024 READ: fetch_mem_rd=1; wait counter cleared on entry and incremented each cycle that fetch_mem_ready=0.
REQ-025 READ with fetch_mem_ready=1: at that edge, fetch_instr<=fetch_mem_data, PC<=PC+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00), next state DONE.
REQ-026 READ with fetch_mem_ready=0 and wait counter==TIMEOUT-1: next state ERR; PC and fetch_instr unchanged; READ never lasts more than TIMEOUT cycles.
REQ-027 DONE: fetch_instr_valid=1 for one cycle; next state IDLE.
REQ-028 ERR: fetch_err=1 for one cycle; next state IDLE.
REQ-029 Latency: the earliest possible fetch_instr_valid is 3 cycles after the edge that samples fetch_start (LOAD_ADDR, READ with ready, DONE).
REQ-030 fetch_start and fetch_jump are ignored in all states other than IDLE; they are neither queued nor counted.
REQ-031 fetch_mem_ready is ignored outside READ.
REQ-032 fetch_instr holds its value between fetches and after an error.

Reset
REQ-033 fetch_rst_n=0 asynchronously forces state IDLE, PC=RESET_PC, fetch_instr=0 and wait counter=0; all strobes and fetch_busy go low.
REQ-034 Reset asserted during any fetch aborts it with no fetch_instr_valid or fetch_err pulse.
REQ-035 After reset deassertion, the first fetch uses RESET_PC.

Structure
REQ-036 Shared package fetch_pkg holds the state enumeration and the default ADDR_W, DATA_W and TIMEOUT constants.
REQ-037 The wait counter is a sub-module, fetch_timer, with clear, enable, terminal-count output and the same clock and reset.
REQ-038 The PC, fetch_instr and state registers are held in fetch_ctrl.

Verification
REQ-039 Reset, then start, with ready high on the first READ cycle and data 8'hA5 -> addr_wr_en on cycle 1, mem_rd on cycle 2, valid pulse on cycle 3, instr=8'hA5, PC=8'h01.
REQ-040 Jump and start together with jump_addr=8'hFF and data 8'h3C -> addr_out=8'hFF during LOAD_ADDR, instr=8'h3C, PC wraps to 8'h00.
REQ-041 Start with ready held low -> mem_rd high for exactly 15 cycles, one err pulse, PC and instr unchanged, busy low afterwards.
REQ-042 Ready asserted on the 15th READ cycle -> valid pulse and no err pulse.
REQ-043 Start and jump pulsed while busy -> no effect on PC or on the number of fetches performed.
REQ-044 fetch_rst_n pulsed low mid-READ -> immediate IDLE, PC=RESET_PC, instr=0, no valid or err pulse.
